// File: rtl/id_scoreboard_if.sv
// Decode-side bundle between the decoder/pipeline and id_scoreboard.
// The master modport is the surrounding pipeline; the slave modport is the scoreboard.
interface id_scoreboard_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) ();

  // Instruction in ID
  logic              id_valid_i;
  logic              src1_re_i;
  logic              src2_re_i;
  logic [ADDR_W-1:0] src1_addr_i;
  logic [ADDR_W-1:0] src2_addr_i;
  logic [DATA_W-1:0] rf1_data_i;
  logic [DATA_W-1:0] rf2_data_i;
  logic [DATA_W-1:0] imm_i;
  logic              dst_we_i;
  logic [ADDR_W-1:0] dst_addr_i;

  // Forwarding and retirement sources
  logic              ex_we_i;
  logic [ADDR_W-1:0] ex_addr_i;
  logic [DATA_W-1:0] ex_data_i;
  logic              mem_we_i;
  logic [ADDR_W-1:0] mem_addr_i;
  logic [DATA_W-1:0] mem_data_i;
  logic              wb_we_i;
  logic [ADDR_W-1:0] wb_addr_i;
  logic [DATA_W-1:0] wb_data_i;

  // Pipeline control
  logic              ex_stall_i;
  logic              flush_i;

  // Results
  logic              stall_o;
  logic              issue_o;
  logic              ex_valid_o;
  logic [DATA_W-1:0] op1_o;
  logic [DATA_W-1:0] op2_o;
  logic [ADDR_W-1:0] wd_o;
  logic              wreg_o;

  modport master (
    output id_valid_i, src1_re_i, src2_re_i, src1_addr_i, src2_addr_i,
    output rf1_data_i, rf2_data_i, imm_i, dst_we_i, dst_addr_i,
    output ex_we_i, ex_addr_i, ex_data_i,
    output mem_we_i, mem_addr_i, mem_data_i,
    output wb_we_i, wb_addr_i, wb_data_i,
    output ex_stall_i, flush_i,
    input  stall_o, issue_o, ex_valid_o, op1_o, op2_o, wd_o, wreg_o
  );

  modport slave (
    input  id_valid_i, src1_re_i, src2_re_i, src1_addr_i, src2_addr_i,
    input  rf1_data_i, rf2_data_i, imm_i, dst_we_i, dst_addr_i,
    input  ex_we_i, ex_addr_i, ex_data_i,
    input  mem_we_i, mem_addr_i, mem_data_i,
    input  wb_we_i, wb_addr_i, wb_data_i,
    input  ex_stall_i, flush_i,
    output stall_o, issue_o, ex_valid_o, op1_o, op2_o, wd_o, wreg_o
  );

endinterface

// File: rtl/id_scoreboard.sv
// Decode-side operand resolver with per-register in-flight write scoreboard,
// EX/MEM/WB forwarding, ID stall generation and the ID/EX issue register.
module id_scoreboard #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned CNT_W  = 2
) (
  input logic           clk,
  input logic           rst,
  id_scoreboard_if.slave bus
);

  localparam int unsigned NREG  = 2 ** ADDR_W;
  localparam int unsigned SUM_W = CNT_W + 2;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0]  cnt_q [NREG];
  logic [CNT_W-1:0]  cnt_d [NREG];

  logic              ex_valid_q;
  logic              wreg_q;
  logic [ADDR_W-1:0] wd_q;
  logic [DATA_W-1:0] op1_q;
  logic [DATA_W-1:0] op2_q;

  logic              ex_hit1, mem_hit1, wb_hit1;
  logic              ex_hit2, mem_hit2, wb_hit2;
  logic              haz1, haz2, haz_sat;
  logic              stall_c, issue_c;
  logic [DATA_W-1:0] op1_c, op2_c;

  // Forward hits per source; register 0 is never forwarded
  always_comb begin
    ex_hit1  = bus.ex_we_i  && (bus.ex_addr_i  == bus.src1_addr_i);
    mem_hit1 = bus.mem_we_i && (bus.mem_addr_i == bus.src1_addr_i);
    wb_hit1  = bus.wb_we_i  && (bus.wb_addr_i  == bus.src1_addr_i);
    ex_hit2  = bus.ex_we_i  && (bus.ex_addr_i  == bus.src2_addr_i);
    mem_hit2 = bus.mem_we_i && (bus.mem_addr_i == bus.src2_addr_i);
    wb_hit2  = bus.wb_we_i  && (bus.wb_addr_i  == bus.src2_addr_i);
  end

  // Operand 1 resolution: imm, zero register, then EX > MEM > WB > RF
  always_comb begin
    op1_c = bus.rf1_data_i;
    if (!bus.src1_re_i)                 op1_c = bus.imm_i;
    else if (bus.src1_addr_i == '0)     op1_c = '0;
    else if (ex_hit1)                   op1_c = bus.ex_data_i;
    else if (mem_hit1)                  op1_c = bus.mem_data_i;
    else if (wb_hit1)                   op1_c = bus.wb_data_i;
  end

  // Operand 2 resolution, reading its own register-file port
  always_comb begin
    op2_c = bus.rf2_data_i;
    if (!bus.src2_re_i)                 op2_c = bus.imm_i;
    else if (bus.src2_addr_i == '0)     op2_c = '0;
    else if (ex_hit2)                   op2_c = bus.ex_data_i;
    else if (mem_hit2)                  op2_c = bus.mem_data_i;
    else if (wb_hit2)                   op2_c = bus.wb_data_i;
  end

  // A pending source with no forward, or a saturated destination counter, stalls ID
  always_comb begin
    haz1    = bus.src1_re_i && (bus.src1_addr_i != '0) &&
              (cnt_q[bus.src1_addr_i] != '0) && !(ex_hit1 || mem_hit1 || wb_hit1);
    haz2    = bus.src2_re_i && (bus.src2_addr_i != '0) &&
              (cnt_q[bus.src2_addr_i] != '0) && !(ex_hit2 || mem_hit2 || wb_hit2);
    haz_sat = bus.dst_we_i && (bus.dst_addr_i != '0) &&
              (cnt_q[bus.dst_addr_i] == CNT_MAX);
    stall_c = bus.id_valid_i && (haz1 || haz2 || haz_sat) && !bus.flush_i;
    issue_c = bus.id_valid_i && !stall_c && !bus.ex_stall_i && !bus.flush_i;
  end

  // Scoreboard next state: issue increments, WB and flushed-writer decrement, floor at 0
  always_comb begin
    logic             inc;
    logic             dec_wb;
    logic             dec_fl;
    logic [SUM_W-1:0] up;
    logic [SUM_W-1:0] dn;
    for (int unsigned r = 0; r < NREG; r++) begin
      inc    = issue_c && bus.dst_we_i && (bus.dst_addr_i == ADDR_W'(r));
      dec_wb = bus.wb_we_i && (bus.wb_addr_i == ADDR_W'(r));
      dec_fl = bus.flush_i && ex_valid_q && wreg_q && (wd_q == ADDR_W'(r));
      up     = SUM_W'(cnt_q[r]) + SUM_W'(inc);
      dn     = SUM_W'(dec_wb) + SUM_W'(dec_fl);
      if (r == 0 || up <= dn)
        cnt_d[r] = '0;
      else if ((up - dn) > SUM_W'(CNT_MAX))
        cnt_d[r] = CNT_MAX;
      else
        cnt_d[r] = CNT_W'(up - dn);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned r = 0; r < NREG; r++) cnt_q[r] <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // ID/EX register: flush > hold > issue > bubble; operands only change on issue
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_valid_q <= 1'b0;
      wreg_q     <= 1'b0;
      wd_q       <= '0;
      op1_q      <= '0;
      op2_q      <= '0;
    end else if (bus.flush_i) begin
      ex_valid_q <= 1'b0;
      wreg_q     <= 1'b0;
    end else if (bus.ex_stall_i) begin
      ex_valid_q <= ex_valid_q;
    end else if (issue_c) begin
      ex_valid_q <= 1'b1;
      wreg_q     <= bus.dst_we_i;
      wd_q       <= bus.dst_addr_i;
      op1_q      <= op1_c;
      op2_q      <= op2_c;
    end else begin
      ex_valid_q <= 1'b0;
      wreg_q     <= 1'b0;
    end
  end

  assign bus.stall_o    = stall_c;
  assign bus.issue_o    = issue_c;
  assign bus.ex_valid_o = ex_valid_q;
  assign bus.wreg_o     = wreg_q;
  assign bus.wd_o       = wd_q;
  assign bus.op1_o      = op1_q;
  assign bus.op2_o      = op2_q;

endmodule

// File: tb/tb_id_scoreboard.sv
// Scoreboard-driven bench for id_scoreboard: expected ID/EX contents are queued
// at issue and popped when the DUT presents a live ID/EX entry.
module tb_id_scoreboard;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned CNT_W  = 2;

  typedef struct packed {
    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;
    logic [ADDR_W-1:0] wd;
    logic              wreg;
  } idex_t;

  logic clk;
  logic rst;
  int   nvec;
  int   nmis;
  idex_t q[$];
  idex_t last;
  logic  last_valid;

  id_scoreboard_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  id_scoreboard #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic clr();
    bus.id_valid_i  = 1'b0;
    bus.src1_re_i   = 1'b0;
    bus.src2_re_i   = 1'b0;
    bus.src1_addr_i = '0;
    bus.src2_addr_i = '0;
    bus.rf1_data_i  = '0;
    bus.rf2_data_i  = '0;
    bus.imm_i       = '0;
    bus.dst_we_i    = 1'b0;
    bus.dst_addr_i  = '0;
    bus.ex_we_i     = 1'b0;
    bus.ex_addr_i   = '0;
    bus.ex_data_i   = '0;
    bus.mem_we_i    = 1'b0;
    bus.mem_addr_i  = '0;
    bus.mem_data_i  = '0;
    bus.wb_we_i     = 1'b0;
    bus.wb_addr_i   = '0;
    bus.wb_data_i   = '0;
    bus.ex_stall_i  = 1'b0;
    bus.flush_i     = 1'b0;
  endtask

  // Inputs are already driven; check comb outputs, queue expectation, clock, check ID/EX
  task automatic cyc(input logic e_stall, input logic e_issue,
                     input logic [DATA_W-1:0] e1, input logic [DATA_W-1:0] e2);
    logic  hold;
    idex_t ent;
    #2;
    chk("stall", 64'(bus.stall_o), 64'(e_stall));
    chk("issue", 64'(bus.issue_o), 64'(e_issue));
    if (e_issue) begin
      ent.op1  = e1;
      ent.op2  = e2;
      ent.wd   = bus.dst_addr_i;
      ent.wreg = bus.dst_we_i;
      q.push_back(ent);
    end
    hold = bus.ex_stall_i && !bus.flush_i;
    @(posedge clk);
    #1;
    if (hold) begin
      chk("hold_valid", 64'(bus.ex_valid_o), 64'(last_valid));
      chk("hold_op1", 64'(bus.op1_o), 64'(last.op1));
    end else if (bus.ex_valid_o) begin
      if (q.size() == 0) begin
        chk("spurious_valid", 64'(bus.ex_valid_o), 64'(0));
      end else begin
        last = q.pop_front();
        chk("op1", 64'(bus.op1_o), 64'(last.op1));
        chk("op2", 64'(bus.op2_o), 64'(last.op2));
        chk("wd", 64'(bus.wd_o), 64'(last.wd));
        chk("wreg", 64'(bus.wreg_o), 64'(last.wreg));
      end
      last_valid = 1'b1;
    end else begin
      chk("valid_drop", 64'(q.size()), 64'(0));
      chk("bubble_wreg", 64'(bus.wreg_o), 64'(0));
      chk("bubble_op1", 64'(bus.op1_o), 64'(last.op1));
      chk("bubble_op2", 64'(bus.op2_o), 64'(last.op2));
      last_valid = 1'b0;
    end
    clr();
  endtask

  // Source setup helpers
  task automatic src(input int n, input logic re, input logic [ADDR_W-1:0] a,
                     input logic [DATA_W-1:0] rf);
    if (n == 1) begin
      bus.src1_re_i = re; bus.src1_addr_i = a; bus.rf1_data_i = rf;
    end else begin
      bus.src2_re_i = re; bus.src2_addr_i = a; bus.rf2_data_i = rf;
    end
  endtask

  task automatic dst(input logic [ADDR_W-1:0] a);
    bus.dst_we_i = 1'b1; bus.dst_addr_i = a;
  endtask

  task automatic wb(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    bus.wb_we_i = 1'b1; bus.wb_addr_i = a; bus.wb_data_i = d;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    nvec = 0;
    nmis = 0;
    last = '0;
    last_valid = 1'b0;
    rst = 1'b0;
    clr();
    #3;
    chk("rst_valid", 64'(bus.ex_valid_o), 64'(0));
    chk("rst_wreg", 64'(bus.wreg_o), 64'(0));
    chk("rst_wd", 64'(bus.wd_o), 64'(0));
    chk("rst_op1", 64'(bus.op1_o), 64'(0));
    chk("rst_op2", 64'(bus.op2_o), 64'(0));
    chk("rst_stall", 64'(bus.stall_o), 64'(0));
    chk("rst_issue", 64'(bus.issue_o), 64'(0));
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // ori r1 then addu r2,r1,r1 forwarded from EX
    bus.id_valid_i = 1; src(1, 1, 0, 32'h9999); bus.imm_i = 32'h1234; dst(1);
    cyc(0, 1, 32'h0, 32'h1234);
    bus.id_valid_i = 1; src(1, 1, 1, 32'hDEAD); src(2, 1, 1, 32'hBEEF); dst(2);
    bus.ex_we_i = 1; bus.ex_addr_i = 1; bus.ex_data_i = 32'h1234;
    cyc(0, 1, 32'h1234, 32'h1234);
    wb(1, 32'h1234); cyc(0, 0, 0, 0);
    wb(2, 32'h2468); cyc(0, 0, 0, 0);

    // mul r3 then dependent read stalls until WB
    bus.id_valid_i = 1; src(1, 1, 4, 32'd6); src(2, 1, 5, 32'd7); dst(3);
    cyc(0, 1, 32'd6, 32'd7);
    for (int i = 0; i < 3; i++) begin
      bus.id_valid_i = 1; src(1, 1, 3, 32'hBAD); src(2, 1, 0, 32'hBAD); dst(6);
      cyc(1, 0, 0, 0);
    end
    bus.id_valid_i = 1; src(1, 1, 3, 32'hBAD); src(2, 1, 0, 32'hBAD); dst(6);
    wb(3, 32'h55);
    cyc(0, 1, 32'h55, 32'h0);
    bus.id_valid_i = 1; src(1, 1, 3, 32'h55);
    cyc(0, 1, 32'h55, 32'h0);
    wb(6, 32'h1); cyc(0, 0, 0, 0);

    // r0 reads as zero even when EX claims it
    bus.id_valid_i = 1; src(1, 1, 0, 32'hFFFF_FFFF); src(2, 1, 0, 32'hFFFF_FFFF);
    bus.ex_we_i = 1; bus.ex_addr_i = 0; bus.ex_data_i = 32'hBEEF;
    cyc(0, 1, 32'h0, 32'h0);

    // Source 2 uses its own RF port; immediate when not read
    bus.id_valid_i = 1; src(1, 1, 8, 32'hA); src(2, 1, 9, 32'hB);
    cyc(0, 1, 32'hA, 32'hB);
    bus.id_valid_i = 1; src(1, 1, 8, 32'hA); src(2, 0, 9, 32'hB); bus.imm_i = 32'h0000_FFFF;
    cyc(0, 1, 32'hA, 32'hFFFF);

    // Forward priority EX > MEM, MEM > WB; WB to an idle register must not underflow
    bus.id_valid_i = 1; src(1, 1, 10, 32'h0); src(2, 1, 11, 32'h0);
    bus.ex_we_i = 1; bus.ex_addr_i = 10; bus.ex_data_i = 32'h111;
    bus.mem_we_i = 1; bus.mem_addr_i = 10; bus.mem_data_i = 32'h222;
    wb(11, 32'h555);
    cyc(0, 1, 32'h111, 32'h555);
    bus.id_valid_i = 1; src(1, 1, 10, 32'h0); src(2, 1, 11, 32'h777);
    bus.mem_we_i = 1; bus.mem_addr_i = 10; bus.mem_data_i = 32'h222;
    wb(10, 32'h333);
    cyc(0, 1, 32'h222, 32'h777);
    bus.id_valid_i = 1; src(1, 1, 10, 32'h10); src(2, 1, 11, 32'h11);
    cyc(0, 1, 32'h10, 32'h11);

    // Flush of a writer in ID/EX releases its scoreboard entry
    bus.id_valid_i = 1; bus.imm_i = 32'h1; dst(5);
    cyc(0, 1, 32'h1, 32'h1);
    bus.id_valid_i = 1; src(1, 1, 5, 32'h0); bus.flush_i = 1;
    cyc(0, 0, 0, 0);
    bus.id_valid_i = 1; src(1, 1, 5, 32'h50); dst(5);
    cyc(0, 1, 32'h50, 32'h0);
    bus.id_valid_i = 1; bus.imm_i = 32'h2; dst(5); wb(5, 32'h50);
    cyc(0, 1, 32'h2, 32'h2);
    bus.id_valid_i = 1; src(1, 1, 5, 32'h0);
    cyc(1, 0, 0, 0);
    bus.id_valid_i = 1; src(1, 1, 5, 32'h0); wb(5, 32'h5A);
    cyc(0, 1, 32'h5A, 32'h0);
    bus.id_valid_i = 1; src(1, 1, 5, 32'h5B);
    cyc(0, 1, 32'h5B, 32'h0);

    // Counter saturation on r7
    for (int i = 0; i < 3; i++) begin
      bus.id_valid_i = 1; bus.imm_i = 32'h70 + 32'(i); dst(7);
      cyc(0, 1, 32'h70 + 32'(i), 32'h70 + 32'(i));
    end
    for (int i = 0; i < 2; i++) begin
      bus.id_valid_i = 1; bus.imm_i = 32'h73; dst(7);
      cyc(1, 0, 0, 0);
    end
    bus.id_valid_i = 1; bus.imm_i = 32'h73; dst(7); wb(7, 32'h0);
    cyc(1, 0, 0, 0);
    bus.id_valid_i = 1; bus.imm_i = 32'h73; dst(7);
    cyc(0, 1, 32'h73, 32'h73);
    for (int i = 0; i < 4; i++) begin
      wb(7, 32'h0); cyc(0, 0, 0, 0);
    end
    bus.id_valid_i = 1; src(1, 1, 7, 32'h9);
    cyc(0, 1, 32'h9, 32'h0);

    // EX stall holds the ID/EX register, then a bubble keeps operands
    bus.id_valid_i = 1; bus.imm_i = 32'hABC;
    cyc(0, 1, 32'hABC, 32'hABC);
    bus.id_valid_i = 1; bus.imm_i = 32'hDEF; bus.ex_stall_i = 1;
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);

    // Asynchronous reset in the middle of a stall clears all pending state
    bus.id_valid_i = 1; bus.imm_i = 32'hC; dst(12);
    cyc(0, 1, 32'hC, 32'hC);
    bus.id_valid_i = 1; src(1, 1, 12, 32'h0);
    #2;
    chk("pre_rst_stall", 64'(bus.stall_o), 64'(1));
    rst = 1'b0;
    #1;
    chk("async_valid", 64'(bus.ex_valid_o), 64'(0));
    chk("async_op1", 64'(bus.op1_o), 64'(0));
    chk("async_stall", 64'(bus.stall_o), 64'(0));
    @(posedge clk); #1;
    rst = 1'b1;
    last = '0;
    last_valid = 1'b0;
    clr();
    bus.id_valid_i = 1; src(1, 1, 12, 32'hC0);
    cyc(0, 1, 32'hC0, 32'h0);

    chk("queue_empty", 64'(q.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/id_scoreboard.md
# id_scoreboard

Parametrised decode-side operand resolver and ID/EX issue register for the OpenMIPS pipeline. It tracks in-flight register writes in a per-register scoreboard and forwards operands from EX, MEM and WB with fixed priority. It stalls ID when a source is still pending and no forward can supply it, and holds or flushes the ID/EX register. The block sits between the decoder and EX, replacing pure-combinational forwarding so that multi-cycle producers (mul/div, loads) are handled safely.

## Interface
Parameters:
- DATA_W, 32, operand/data width
- ADDR_W, 5, register address width; NREG = 2**ADDR_W registers
- CNT_W, 2, per-register in-flight writer counter width (max 2**CNT_W-1 writers)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- id_valid_i  in  1  decoded instruction present in ID
- src1_re_i, src2_re_i  in  1 each  source read enables
- src1_addr_i, src2_addr_i  in  ADDR_W each  source register addresses
- rf1_data_i, rf2_data_i  in  DATA_W each  register-file read data
- imm_i  in  DATA_W  extended immediate
- dst_we_i  in  1  instruction writes a register
- dst_addr_i  in  ADDR_W  destination register
- ex_we_i / ex_addr_i / ex_data_i  in  1/ADDR_W/DATA_W  EX result, valid only when final
- mem_we_i / mem_addr_i / mem_data_i  in  1/ADDR_W/DATA_W  MEM result
- wb_we_i / wb_addr_i / wb_data_i  in  1/ADDR_W/DATA_W  write-back; retires a scoreboard entry
- ex_stall_i  in  1  EX cannot accept; hold ID/EX
- flush_i  in  1  kill ID instruction and ID/EX contents
- stall_o  out  1  ID must hold (combinational)
- issue_o  out  1  ID instruction accepted this cycle (combinational)
- ex_valid_o  out  1  ID/EX holds a live instruction
- op1_o, op2_o  out  DATA_W each  resolved operands (registered)
- wd_o  out  ADDR_W  destination (registered)
- wreg_o  out  1  write enable (registered)

## Operation
- Scoreboard: cnt[r], CNT_W bits, r = 1..NREG-1. Register 0 is never pending and always reads as zero.
- Resolution per source s with re=1 and addr≠0, first match wins:
  - EX hit (ex_we_i && ex_addr_i==addr) → ex_data_i
  - MEM hit → mem_data_i
  - WB hit → wb_data_i
  - otherwise rf data
- Resolution with re=1 and addr=0 → 0.
- Resolution with re=0 → imm_i. Source 2 uses rf2_data_i, never rf1_data_i.
- Hazard on a source: re=1, addr≠0, cnt[addr]≠0, and no EX/MEM/WB hit.
- Also a hazard: dst_we_i && dst_addr_i≠0 && cnt[dst_addr_i] == max (saturation).
- stall_o = id_valid_i && (any hazard) && !flush_i.
- issue_o = id_valid_i && !stall_o && !ex_stall_i && !flush_i.
- ID/EX register update, in priority order:
  - flush_i → ex_valid_o=0, wreg_o=0
  - else ex_stall_i → hold all
  - else issue_o → load op1/op2/wd/wreg, ex_valid_o=1
  - else bubble → ex_valid_o=0, wreg_o=0, operands unchanged
- Scoreboard counting:
  - inc: issue_o && dst_we_i && dst_addr_i≠0, on cnt[dst_addr_i]
  - dec: wb_we_i && wb_addr_i≠0, on cnt[wb_addr_i]
  - dec: flush_i && ex_valid_o && wreg_o && wd_o≠0, on cnt[wd_o] (the killed instruction never writes back)
  - Net change per register per cycle is the sum of its incs and decs. The result saturates at 0 and never underflows.
- Non-final EX results (multi-cycle ops) keep ex_we_i low, so dependents stall via the scoreboard.

## Timing
- Reset (rst=0, asynchronous): all cnt=0, ex_valid_o=0, wreg_o=0, wd_o=0, op1_o=op2_o=0. stall_o and issue_o follow their equations with zero state.
- stall_o and issue_o are combinational in the same cycle. Operands appear on op*_o one cycle after issue_o.
- Scoreboard updates take effect at the rising edge and are visible to resolution the following cycle.
- Issue of dst=r and WB of r in the same cycle: cnt[r] unchanged.
- Back-to-back dependents resolve through EX forwarding with no bubble if the producer's ex_we_i is high.
- Reset asserted mid-stall: all state cleared immediately; no pending entries survive.

## Test plan
- Reset release, then ori r1 then addu r2,r1,r1 with EX forward (ex_we=1, ex_addr=1, ex_data=0x1234) → no stall; cycle+1 op1_o=op2_o=0x1234.
- Issue mul to r3, dependent read of r3 with ex_we=0 for 3 cycles → stall_o=1 for 3 cycles. WB r3=0x55 in cycle 4 → issue, op1_o=0x55, cnt[3]=0.
- Read r0 with rf data 0xFFFF_FFFF while EX claims r0 → operand=0, no stall.
- src2_re=1 with rf1=0xA, rf2=0xB → op2_o=0xB. src2_re=0, imm=0x0000_FFFF → op2_o=0xFFFF.
- Issue write to r5, then flush_i while it sits in ID/EX → ex_valid_o=0 next cycle, cnt[5]=0. Simultaneous issue r5 plus WB r5 → cnt unchanged.
- Three outstanding writes to r7 with CNT_W=2 (cnt=3), fourth writer → stall_o=1 until one WB retires.
